// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory access controller
//
// Purpose: FSM state and operation encodings, byte-lane geometry, and the
//          load/store + byte flag decode used when a request is accepted.
// Ports:   none (package).
package dmem_pkg;

  localparam int LANE_W  = 8;   // bits per byte lane
  localparam int N_LANES = 4;   // lanes per 32-bit word
  localparam int OFF_W   = 2;   // byte-offset bits inside a word

  typedef logic [OFF_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } dmem_state_e;

  typedef enum logic [1:0] {
    OP_LW,
    OP_LBU,
    OP_SW,
    OP_SB
  } dmem_op_e;

  // Load wins if decode ever raises both flags.
  function automatic dmem_op_e decode_op(input logic is_load, input logic is_byte);
    if (is_load) return is_byte ? OP_LBU : OP_LW;
    return is_byte ? OP_SB : OP_SW;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - combinational byte extract and byte merge on a 32-bit word
//
// Purpose: LBU extraction (zero-extended) and SB merge for read-modify-write.
// Ports:
//   word_i   in  word read from memory
//   lane_i   in  byte lane (little-endian, lane n = bits [8n+7:8n])
//   byte_i   in  byte to insert for SB
//   ext_o    out selected lane, zero-extended
//   merged_o out word_i with lane_i replaced by byte_i
module byte_lane_unit
  import dmem_pkg::*;
(
  input  logic [N_LANES*LANE_W-1:0] word_i,
  input  lane_t                     lane_i,
  input  logic [LANE_W-1:0]         byte_i,
  output logic [N_LANES*LANE_W-1:0] ext_o,
  output logic [N_LANES*LANE_W-1:0] merged_o
);

  always_comb begin
    ext_o                               = '0;
    ext_o[LANE_W-1:0]                   = word_i[lane_i*LANE_W +: LANE_W];
    merged_o                            = word_i;
    merged_o[lane_i*LANE_W +: LANE_W]   = byte_i;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences LW/LBU/SW/SB onto a word-wide handshaked memory port
//
// Purpose: stalls the core while an access is in flight, turns SB into a
//          read-modify-write, returns load data, flags misalignment and timeout.
// Ports:
//   clk, reset                         clock, async active-high reset
//   req_i, is_load_i, is_store_i,
//   is_byte_i, addr_i, store_data_i    decoded memory op from the core
//   stall_o                            hold current instruction
//   load_valid_o, load_data_o          one-cycle load return, held data
//   err_o                              one-cycle misaligned/timeout pulse
//   mem_valid_o, mem_wen_o,
//   mem_addr_o, mem_wdata_o            registered memory request
//   mem_yumi_i                         memory accepts request
//   mem_rvalid_i, mem_rdata_i          read response
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              is_byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              err_o,
  output logic              mem_valid_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_yumi_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  dmem_state_e       state_q, state_d;
  dmem_op_e          op_q, op_d;
  lane_t             lane_q, lane_d;
  logic [LANE_W-1:0] sbyte_q, sbyte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              err_q, err_d;
  logic              stall;

  logic [DATA_W-1:0] ext_byte;
  logic [DATA_W-1:0] merged_word;

  byte_lane_unit u_lane (
    .word_i   (mem_rdata_i),
    .lane_i   (lane_q),
    .byte_i   (sbyte_q),
    .ext_o    (ext_byte),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lane_d       = lane_q;
    sbyte_d      = sbyte_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A request that is neither load nor store is dropped without stalling.
        if (req_i && (is_load_i || is_store_i)) begin
          stall      = 1'b1;
          op_d       = decode_op(is_load_i, is_byte_i);
          lane_d     = addr_i[OFF_W-1:0];
          sbyte_d    = store_data_i[LANE_W-1:0];
          mem_addr_d = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (!is_byte_i && (addr_i[OFF_W-1:0] != '0)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (is_load_i || is_byte_i) begin
            // SB needs the current word first so the other lanes survive.
            state_d = RD_REQ;
          end else begin
            mem_wdata_d = store_data_i;
            state_d     = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        stall = 1'b1;
        if (mem_yumi_i) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // rvalid is checked before the timeout so a last-cycle response still lands.
        if (mem_rvalid_i) begin
          if (op_q == OP_SB) begin
            mem_wdata_d = merged_word;
            state_d     = WR_REQ;
          end else begin
            load_data_d  = (op_q == OP_LBU) ? ext_byte : mem_rdata_i;
            load_valid_d = 1'b1;
            state_d      = DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WR_REQ: begin
        stall = 1'b1;
        if (mem_yumi_i) state_d = DONE;
      end

      DONE: begin
        // req_i is ignored here; the core retires the instruction this cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Request outputs are registered, so they follow the state being entered.
    mem_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_wen_d   = (state_d == WR_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_LW;
      lane_q       <= '0;
      sbyte_q      <= '0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      sbyte_q      <= sbyte_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end

  assign stall_o      = stall;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;
  assign err_o        = err_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 255;
  localparam int K_LOAD  = 0;
  localparam int K_WRITE = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, is_load_i, is_store_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic        stall_o, load_valid_o, err_o;
  logic [31:0] load_data_o;
  logic        mem_valid_o, mem_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_yumi_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  exp_t        sb_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;

  int          yumi_delay  = 0;
  bit          rd_suppress = 1'b0;
  bit          rd_pend     = 1'b0;
  logic [31:0] rd_addr     = '0;
  int          valid_cycles = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .is_byte_i    (is_byte_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .load_valid_o (load_valid_o),
    .load_data_o  (load_data_o),
    .err_o        (err_o),
    .mem_valid_o  (mem_valid_o),
    .mem_wen_o    (mem_wen_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_yumi_i   (mem_yumi_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push_exp(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Drive one core op and hold it until stall drops; returns stalled cycles.
  task automatic do_op(input bit ld, input bit st, input bit by,
                       input logic [31:0] a, input logic [31:0] sd, output int stalls);
    int guard;
    @(negedge clk);
    req_i = 1'b1; is_load_i = ld; is_store_i = st; is_byte_i = by;
    addr_i = a; store_data_i = sd;
    valid_cycles = 0;
    stalls = 0;
    guard  = 0;
    #1;
    while (stall_o && guard < 2000) begin
      stalls++;
      guard++;
      @(negedge clk);
      #1;
    end
    if (guard >= 2000) check("op_guard", 32'd1, 32'd0);
    req_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
  endtask

  // Memory model: yumi after yumi_delay valid cycles, read data the cycle after yumi.
  initial begin
    int          wait_cnt;
    logic [31:0] hold_addr;
    exp_t        e;
    wait_cnt = 0;
    hold_addr = '0;
    mem_yumi_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rd_pend && !rd_suppress) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem[rd_addr];
        rd_pend      = 1'b0;
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
      mem_yumi_i = 1'b0;
      if (mem_valid_o && !reset) begin
        valid_cycles++;
        if (wait_cnt == 0) hold_addr = mem_addr_o;
        else check("addr_stable", mem_addr_o, hold_addr);
        if (wait_cnt >= yumi_delay) begin
          mem_yumi_i = 1'b1;
          wait_cnt   = 0;
          if (mem_wen_o) begin
            if (sb_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
              e = sb_q.pop_front();
              check("write_kind", 32'(e.kind), 32'(K_WRITE));
              check("write_addr", mem_addr_o, e.addr);
              check("write_data", mem_wdata_o, e.data);
            end
            mem[mem_addr_o] = mem_wdata_o;
          end else begin
            rd_pend = 1'b1;
            rd_addr = mem_addr_o;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor: load returns and error pulses pop the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (load_valid_o || err_o) begin
        if (sb_q.size() == 0) check("unexpected_event", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          if (err_o) begin
            check("err_kind", 32'(e.kind), 32'(K_ERR));
            check("err_no_load_valid", {31'd0, load_valid_o}, 32'd0);
          end else begin
            check("load_kind", 32'(e.kind), 32'(K_LOAD));
            check("load_data", load_data_o, e.data);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          st;
    int          g;
    logic [31:0] last_load;

    reset = 1'b1;
    req_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
    addr_i = '0; store_data_i = '0;
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h20] = 32'h1122_3344;
    mem[32'h40] = 32'h0BAD_0BAD;
    mem[32'h50] = 32'h5566_7788;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {27'd0, stall_o, load_valid_o, err_o, mem_valid_o, mem_wen_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_ldata", load_data_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LW aligned
    push_exp(K_LOAD, 0, 32'hDEAD_BEEF);
    do_op(1, 0, 0, 32'h10, 0, st);
    check("lw_stall", 32'(st), 32'd3);
    check("lw_valid_cycles", 32'(valid_cycles), 32'd1);

    // LBU both lanes of the same word
    mem[32'h10] = 32'hA1B2_C3D4;
    push_exp(K_LOAD, 0, 32'h0000_00A1);
    do_op(1, 0, 1, 32'h13, 0, st);
    push_exp(K_LOAD, 0, 32'h0000_00C3);
    do_op(1, 0, 1, 32'h11, 0, st);

    // SB read-modify-write
    push_exp(K_WRITE, 32'h20, 32'h1177_3344);
    do_op(0, 1, 1, 32'h22, 32'h0000_0077, st);
    check("sb_stall", 32'(st), 32'd4);
    check("sb_valid_cycles", 32'(valid_cycles), 32'd2);
    check("sb_ldata_hold", load_data_o, 32'h0000_00C3);

    // Misaligned word ops
    push_exp(K_ERR, 0, 0);
    do_op(0, 1, 0, 32'h06, 32'hFFFF_FFFF, st);
    check("sw_mis_stall", 32'(st), 32'd1);
    check("sw_mis_no_mem", 32'(valid_cycles), 32'd0);
    push_exp(K_ERR, 0, 0);
    do_op(1, 0, 0, 32'h06, 0, st);
    check("lw_mis_stall", 32'(st), 32'd1);
    check("lw_mis_no_mem", 32'(valid_cycles), 32'd0);
    check("lw_mis_ldata_hold", load_data_o, 32'h0000_00C3);

    // SW then read back
    push_exp(K_WRITE, 32'h30, 32'hCAFE_F00D);
    do_op(0, 1, 0, 32'h30, 32'hCAFE_F00D, st);
    check("sw_stall", 32'(st), 32'd2);
    push_exp(K_LOAD, 0, 32'hCAFE_F00D);
    do_op(1, 0, 0, 32'h30, 0, st);

    // Request with neither load nor store is ignored
    do_op(0, 0, 0, 32'h30, 0, st);
    check("nop_stall", 32'(st), 32'd0);
    check("nop_no_mem", 32'(valid_cycles), 32'd0);

    // Delayed yumi then read timeout
    yumi_delay  = 3;
    rd_suppress = 1'b1;
    push_exp(K_ERR, 0, 0);
    do_op(1, 0, 0, 32'h40, 0, st);
    check("to_valid_cycles", 32'(valid_cycles), 32'd4);
    check("to_stall_window", 32'((st >= 1 + 4 + TIMEOUT) && (st <= 1 + 4 + TIMEOUT + 1)), 32'd1);
    check("to_ldata_hold", load_data_o, 32'hCAFE_F00D);
    rd_pend     = 1'b0;
    rd_suppress = 1'b0;
    yumi_delay  = 0;

    // Random LBU / SB mix checked against a shift-and-mask reference
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, w, d;
      logic [1:0]  ln;
      logic [7:0]  b;
      a  = 32'h100 + 32'(i * 4);
      w  = $urandom;
      ln = 2'($urandom_range(0, 3));
      b  = 8'($urandom);
      mem[a] = w;
      if (i % 2 == 0) begin
        push_exp(K_LOAD, 0, (w >> (8 * ln)) & 32'hFF);
        do_op(1, 0, 1, a | 32'(ln), 0, st);
      end else begin
        d = (w & ~(32'hFF << (8 * ln))) | (32'(b) << (8 * ln));
        push_exp(K_WRITE, a, d);
        do_op(0, 1, 1, a | 32'(ln), {24'($urandom), b}, st);
      end
    end

    // Reset during RD_WAIT of an SB: no write may follow
    rd_suppress = 1'b1;
    @(negedge clk);
    req_i = 1'b1; is_store_i = 1'b1; is_byte_i = 1'b1;
    addr_i = 32'h51; store_data_i = 32'h0000_00EE;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (!(mem_valid_o && mem_yumi_i) && g < 50);
    if (g >= 50) check("rst_yumi_guard", 32'd1, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    req_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
    #1;
    check("midrst_ctrl", {27'd0, stall_o, load_valid_o, err_o, mem_valid_o, mem_wen_o}, 32'd0);
    check("midrst_addr", mem_addr_o, 32'd0);
    check("midrst_wdata", mem_wdata_o, 32'd0);
    check("midrst_ldata", load_data_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    rd_pend     = 1'b0;
    rd_suppress = 1'b0;
    check("midrst_mem_unchanged", mem[32'h50], 32'h5566_7788);

    last_load = 32'hA1B2_C3D4;
    push_exp(K_LOAD, 0, last_load);
    do_op(1, 0, 0, 32'h10, 0, st);
    check("post_rst_lw_stall", 32'(st), 32'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the single-issue core, driven by the decode flags for load, store, memory-op and byte-op.
- Converts LW, LBU, SW and SB into word-wide handshaked transactions on a memory port that has no byte enables; SB becomes a read-modify-write.
- Stalls the core until each access completes, returns load data, and flags misaligned accesses and memory timeouts.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; fixed at 32 (4 byte lanes).
- TIMEOUT, 255, maximum cycles to wait in RD_WAIT for mem_rvalid_i before aborting.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  1  decoded memory op valid this cycle (is_mem_op from decode, qualified by core).
- is_load_i  in  1  load op.
- is_store_i  in  1  store op.
- is_byte_i  in  1  byte op (LBU or SB).
- addr_i  in  ADDR_W  effective byte address.
- store_data_i  in  DATA_W  store source register; SB uses bits [7:0].
- stall_o  out  1  core must hold the current instruction.
- load_valid_o  out  1  one-cycle pulse; load_data_o valid.
- load_data_o  out  DATA_W  LW word, or LBU byte zero-extended.
- err_o  out  1  one-cycle pulse: misaligned LW/SW, or timeout.
- mem_valid_o  out  1  request to memory.
- mem_wen_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  word address; bits [1:0] forced to 0.
- mem_wdata_o  out  DATA_W  write data.
- mem_yumi_i  in  1  memory accepts the request this cycle (only with mem_valid_o).
- mem_rvalid_i  in  1  read data valid; no earlier than the cycle after yumi.
- mem_rdata_i  in  DATA_W  read word.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; counter = 0.
  - All outputs 0, including mem_addr_o, mem_wdata_o and load_data_o.
- Reset mid-operation: abandons the transaction immediately; no load_valid_o pulse; memory-side outstanding reads are ignored.
- Little-endian: byte lane = addr[1:0]; lane n = bits [8n+7:8n].
- IDLE:
  - On req_i, latch op, address, store data and lane; stall_o = 1 combinationally.
  - Misaligned word op (is_byte_i = 0 and addr[1:0] != 0) -> DONE with err; no memory access.
  - Load or SB -> RD_REQ.
  - SW -> WR_REQ.
  - req_i with neither is_load_i nor is_store_i -> ignored; stall_o = 0.
- RD_REQ:
  - mem_valid_o = 1, mem_wen_o = 0.
  - On mem_yumi_i -> RD_WAIT with counter cleared.
  - mem_valid_o and address stay stable until yumi.
- RD_WAIT:
  - Counter increments each cycle.
  - On mem_rvalid_i:
    - Load: capture extracted data -> DONE.
    - SB: merge store byte into the read word at the lane; hold as write data -> WR_REQ.
  - Counter == TIMEOUT without rvalid -> DONE with err. rvalid in the same cycle as TIMEOUT wins.
- WR_REQ:
  - mem_valid_o = 1, mem_wen_o = 1, mem_wdata_o = store word or merged word.
  - On mem_yumi_i -> DONE.
- DONE:
  - stall_o = 0.
  - load_valid_o = 1 for loads without error.
  - err_o = 1 if error; load_data_o unchanged on error.
  - Unconditionally -> IDLE.
  - req_i is not sampled in DONE: the core advances this cycle.
- stall_o = 1 in RD_REQ, RD_WAIT, WR_REQ, and in IDLE with an accepted req_i.
- Minimum latencies, yumi same cycle as request:
  - SW: 2 cycles of stall.
  - Load: 3 + read latency.
  - SB: 4 + read latency.
- load_data_o holds its value until the next successful load.
- mem_* outputs are registered from state and latched fields; mem_valid_o is never asserted in IDLE or DONE.

Decomposition:
- Shared package dmem_pkg:
  - dmem_state_e {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE}.
  - dmem_op_e {OP_LW, OP_LBU, OP_SW, OP_SB}.
  - Lane-width and word-offset constants.
- Sub-module byte_lane_unit, combinational:
  - Byte extract with zero-extend.
  - Byte merge into a word by lane.

Test Plan:
- LW addr 0x0000_0010, memory word 0xDEAD_BEEF, yumi immediate, rvalid 1 cycle later -> mem_addr_o = 0x10, load_valid_o pulse with load_data_o = 0xDEAD_BEEF, stall deasserts in DONE.
- LBU addr 0x0000_0013 on word 0xA1B2_C3D4 -> load_data_o = 0x0000_00A1; addr 0x11 -> 0x0000_00C3.
- SB addr 0x0000_0022, store_data 0x0000_0077, memory word 0x1122_3344 -> read at 0x20, then write 0x1177_3344 at 0x20; no load_valid_o.
- SW addr 0x0000_0006 -> err_o pulse, no mem_valid_o, stall_o high exactly 1 cycle; LW addr 0x06 behaves the same.
- LW with yumi delayed 3 cycles, then no rvalid -> mem_valid_o held stable through the delay; err_o after TIMEOUT = 255 wait cycles, FSM back to IDLE.
- Reset asserted in RD_WAIT of an SB -> all outputs 0 asynchronously, no write issued, and a subsequent LW completes normally.
